// File: rtl/disp_pf_pkg.sv
// Shared types for the KS-10 page-fail / interrupt dispatch arbiter.
// Holds the arbiter FSM states and the default microcode dispatch codes.
package disp_pf_pkg;

    typedef enum logic {
        ARMED = 1'b0,
        HOLD  = 1'b1
    } state_t;

    typedef enum logic [3:0] {
        dispNONE       = 4'd0,
        dispINTR       = 4'd1,
        dispNXM        = 4'd5,
        dispWRITEFAIL  = 4'd10,
        dispTIMPAGFAIL = 4'd11,
        dispINVALID    = 4'd12,
        dispMISMATCH   = 4'd13
    } disp_code_t;

endpackage

// File: rtl/disp_pf_arb_prio_enc.sv
// Lowest-index-wins priority encoder with any-request flag and population count.
// Pure combinational; used by disp_pf_arb to pick the dispatch winner.
module prio_enc #(
    parameter int N  = 8,
    parameter int IW = $clog2(N),
    parameter int PW = $clog2(N + 1)
) (
    input  logic [N-1:0]  i_req,
    output logic [IW-1:0] o_idx,
    output logic          o_any,
    output logic [PW-1:0] o_cnt
);

    always_comb begin
        // NOTE: outputs take a default before the loop so no latch can be inferred.
        o_idx = '0;
        o_cnt = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IW'(i);
                o_cnt = o_cnt + PW'(1);
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/disp_pf_arb.sv
// Page-fail / interrupt dispatch arbiter: qualifies NSRC sources against the fetch and
// memory-cycle windows, dispatches the highest-priority one and holds its code until memCLR.
module disp_pf_arb
    import disp_pf_pkg::*;
#(
    parameter int              NSRC      = 8,
    parameter int              DW        = 4,
    parameter logic [NSRC-1:0] INTR_MASK = 8'b0000_0111,
    parameter logic [NSRC-1:0] EDGE_MASK = 8'b0000_0001,
    parameter int              CW        = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clken,
    input  logic                    fetchCYCLE,
    input  logic                    memCYCLE,
    input  logic                    memCLR,
    input  logic [NSRC-1:0]         srcREQ,
    input  logic [NSRC*DW-1:0]      srcCODE,
    output logic                    pageFAIL,
    output logic [DW-1:0]           dispPF,
    output logic [$clog2(NSRC)-1:0] dispSRC,
    output logic                    dispMULTI,
    output logic [CW-1:0]           lostCNT
);

    localparam int SW = $clog2(NSRC);
    localparam int PW = $clog2(NSRC + 1);
    localparam int AW = CW + PW + 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NSRC-1:0] r_pend;
    logic            r_intr_en;
    logic            r_pf_en;
    logic [DW-1:0]   r_disp_pf;
    logic [SW-1:0]   r_disp_src;
    logic            r_disp_multi;
    logic [CW-1:0]   r_lost_cnt;

    logic [NSRC-1:0] w_eff;
    logic [NSRC-1:0] w_win_en;
    logic [NSRC-1:0] w_q;
    logic [NSRC-1:0] w_pend_clr;
    logic [SW-1:0]   w_win;
    logic            w_any;
    logic [PW-1:0]   w_pop;
    logic [DW-1:0]   w_win_code;
    logic [AW-1:0]   w_lost_sum;
    logic [CW-1:0]   w_lost_nxt;
    logic            w_capture;
    logic            w_clear;

    // Edge sources are seen through their pending latch, level sources live.
    assign w_eff    = (EDGE_MASK & r_pend) | (~EDGE_MASK & srcREQ);
    assign w_win_en = ({NSRC{r_intr_en}} & INTR_MASK) | ({NSRC{r_pf_en}} & ~INTR_MASK);
    assign w_q      = (r_state == ARMED) ? (w_eff & w_win_en) : '0;

    prio_enc #(
        .N  (NSRC),
        .IW (SW),
        .PW (PW)
    ) u_prio_enc (
        .i_req (w_q),
        .o_idx (w_win),
        .o_any (w_any),
        .o_cnt (w_pop)
    );

    assign pageFAIL = w_any;

    always_comb begin
        w_win_code = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (w_win == SW'(i)) begin
                w_win_code = srcCODE[i*DW +: DW];
            end
        end
    end

    // Only meaningful on capture, where at least one source is qualified.
    assign w_lost_sum = AW'(r_lost_cnt) + AW'(w_pop) - AW'(1);
    assign w_lost_nxt = (w_lost_sum > AW'({CW{1'b1}})) ? {CW{1'b1}} : w_lost_sum[CW-1:0];

    assign w_pend_clr = w_capture ? (NSRC'(1) << w_win) : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ARMED: begin
                if (w_any) begin
                    w_capture   = 1'b1;
                    w_state_nxt = HOLD;
                end else if (memCLR) begin
                    w_clear = 1'b1;
                end
            end
            HOLD: begin
                if (memCLR) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ARMED;
                end
            end
            default: w_state_nxt = ARMED;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            r_state <= ARMED;
        end else if (clken) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend       <= '0;
            r_intr_en    <= 1'b0;
            r_pf_en      <= 1'b0;
            r_disp_pf    <= DW'(dispNONE);
            r_disp_src   <= '0;
            r_disp_multi <= 1'b0;
            r_lost_cnt   <= '0;
        end else if (clken) begin
            // A new pulse on the dispatched source survives the clear.
            r_pend    <= (r_pend & ~w_pend_clr) | (srcREQ & EDGE_MASK);
            r_intr_en <= fetchCYCLE;
            r_pf_en   <= memCYCLE & ~r_pf_en;
            if (w_capture) begin
                r_disp_pf    <= w_win_code;
                r_disp_src   <= w_win;
                r_disp_multi <= (w_pop > PW'(1));
                r_lost_cnt   <= w_lost_nxt;
            end else if (w_clear) begin
                r_disp_pf    <= DW'(dispNONE);
                r_disp_src   <= '0;
                r_disp_multi <= 1'b0;
            end
        end
    end

    assign dispPF    = r_disp_pf;
    assign dispSRC   = r_disp_src;
    assign dispMULTI = r_disp_multi;
    assign lostCNT   = r_lost_cnt;

endmodule

// File: tb/tb_disp_pf_arb.sv
// Self-checking bench for disp_pf_arb: directed scenarios plus random stimulus against a
// cycle-level behavioural model; a second instance with CW=2 covers lostCNT saturation.
module tb_disp_pf_arb;

    localparam logic [7:0] INTR_M = 8'b0000_0111;
    localparam logic [7:0] EDGE_M = 8'b0000_0001;

    logic        clk = 1'b0;
    logic        rst, clken, fetchCYCLE, memCYCLE, memCLR;
    logic [7:0]  srcREQ;
    logic [31:0] srcCODE;
    logic        pageFAIL, pageFAIL2;
    logic [3:0]  dispPF, dispPF2;
    logic [2:0]  dispSRC, dispSRC2;
    logic        dispMULTI, dispMULTI2;
    logic [7:0]  lostCNT;
    logic [1:0]  lostCNT2;

    always #5 clk = ~clk;

    disp_pf_arb u_dut (
        .clk(clk), .rst(rst), .clken(clken), .fetchCYCLE(fetchCYCLE), .memCYCLE(memCYCLE),
        .memCLR(memCLR), .srcREQ(srcREQ), .srcCODE(srcCODE), .pageFAIL(pageFAIL),
        .dispPF(dispPF), .dispSRC(dispSRC), .dispMULTI(dispMULTI), .lostCNT(lostCNT)
    );

    disp_pf_arb #(.CW(2)) u_dut_sat (
        .clk(clk), .rst(rst), .clken(clken), .fetchCYCLE(fetchCYCLE), .memCYCLE(memCYCLE),
        .memCLR(memCLR), .srcREQ(srcREQ), .srcCODE(srcCODE), .pageFAIL(pageFAIL2),
        .dispPF(dispPF2), .dispSRC(dispSRC2), .dispMULTI(dispMULTI2), .lostCNT(lostCNT2)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit [3:0] code [8];
    bit       m_hold;
    bit [7:0] m_pend;
    bit       m_intr, m_pf;
    bit [3:0] m_disp;
    bit [2:0] m_src;
    bit       m_multi;
    int       m_lost, m_lost2;
    bit       last_pf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit [7:0] model_q(input bit [7:0] req);
        bit [7:0] q = '0;
        for (int i = 0; i < 8; i++) begin
            bit eff  = EDGE_M[i] ? m_pend[i] : req[i];
            bit open = INTR_M[i] ? m_intr : m_pf;
            q[i] = eff && open && !m_hold;
        end
        return q;
    endfunction

    task automatic model_reset();
        m_hold = 0; m_pend = '0; m_intr = 0; m_pf = 0;
        m_disp = '0; m_src = '0; m_multi = 0; m_lost = 0; m_lost2 = 0;
    endtask

    task automatic model_edge(input bit ck, f, m, c, r, input bit [7:0] req);
        bit [7:0] q;
        int n, first;
        if (r) begin
            model_reset();
            return;
        end
        if (!ck) return;
        q = model_q(req);
        n = $countones(q);
        first = -1;
        for (int i = 7; i >= 0; i--) if (q[i]) first = i;
        if (first >= 0) begin
            m_pend[first] = 0;
            m_disp  = code[first];
            m_src   = 3'(first);
            m_multi = (n > 1);
            m_lost  = (m_lost + n - 1 > 255) ? 255 : m_lost + n - 1;
            m_lost2 = (m_lost2 + n - 1 > 3) ? 3 : m_lost2 + n - 1;
            m_hold  = 1;
        end else if (c) begin
            m_disp = '0; m_src = '0; m_multi = 0; m_hold = 0;
        end
        m_pend = m_pend | (req & EDGE_M);
        m_intr = f;
        m_pf   = m && !m_pf;
    endtask

    task automatic step(input bit ck, f, m, c, r, input bit [7:0] req);
        bit exp_pf;
        @(negedge clk);
        clken = ck; fetchCYCLE = f; memCYCLE = m; memCLR = c; rst = r; srcREQ = req;
        for (int i = 0; i < 8; i++) srcCODE[i*4 +: 4] = code[i];
        #1;
        exp_pf = (r == 0 || 1) ? (model_q(req) != 0) : 1'b0;
        last_pf = pageFAIL;
        check("pageFAIL", pageFAIL, exp_pf);
        check("pageFAIL_sat", pageFAIL2, exp_pf);
        @(posedge clk);
        model_edge(ck, f, m, c, r, req);
        #1;
        check("dispPF", dispPF, m_disp);
        check("dispSRC", dispSRC, m_src);
        check("dispMULTI", dispMULTI, m_multi);
        check("lostCNT", lostCNT, m_lost);
        check("lostCNT_sat", lostCNT2, m_lost2);
    endtask

    bit pf_hist [4];

    initial begin
        code[0] = 4'd11; code[1] = 4'd1;  code[2] = 4'd5;  code[3] = 4'd13;
        code[4] = 4'd10; code[5] = 4'd12; code[6] = 4'd7;  code[7] = 4'd3;
        rst = 1; clken = 0; fetchCYCLE = 0; memCYCLE = 0; memCLR = 0; srcREQ = '0;
        for (int i = 0; i < 8; i++) srcCODE[i*4 +: 4] = code[i];
        model_reset();
        // Reset must take effect with clken low.
        repeat (2) @(posedge clk);
        #1;
        check("rst_pageFAIL", pageFAIL, 0);
        check("rst_dispPF", dispPF, 0);
        check("rst_dispSRC", dispSRC, 0);
        check("rst_dispMULTI", dispMULTI, 0);
        check("rst_lostCNT", lostCNT, 0);

        // Single fault: src5 level, code 12.
        step(1, 0, 1, 0, 0, 8'h20);
        check("sf_pf_early", last_pf, 0);
        step(1, 0, 0, 0, 0, 8'h20);
        check("sf_pf", last_pf, 1);
        check("sf_dispPF", dispPF, 12);
        check("sf_dispSRC", dispSRC, 5);
        step(1, 0, 0, 1, 0, 8'h00);
        check("sf_clr", dispPF, 0);

        // Priority / multi: src1 and src2 at fetch.
        step(1, 1, 0, 0, 0, 8'h06);
        step(1, 0, 0, 0, 0, 8'h06);
        check("pm_dispPF", dispPF, 1);
        check("pm_dispSRC", dispSRC, 1);
        check("pm_multi", dispMULTI, 1);
        check("pm_lost", lostCNT, 1);

        // Lockout: pulse src0 during HOLD, dispatched only after release and a fetch.
        step(1, 1, 0, 0, 0, 8'h01);
        step(1, 0, 0, 0, 0, 8'h00);
        check("lo_pf_held", last_pf, 0);
        check("lo_still_1", dispPF, 1);
        step(1, 0, 0, 1, 0, 8'h00);
        step(1, 1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);
        check("lo_pf", last_pf, 1);
        check("lo_dispPF", dispPF, 11);
        check("lo_dispSRC", dispSRC, 0);
        step(1, 0, 0, 1, 0, 8'h00);

        // Window class: fault source in fetch window, interrupt source in memory window.
        step(1, 1, 0, 0, 0, 8'h10);
        step(1, 0, 0, 0, 0, 8'h10);
        check("wc_fault_in_fetch", last_pf, 0);
        step(1, 0, 1, 0, 0, 8'h01);
        step(1, 0, 0, 0, 0, 8'h00);
        check("wc_intr_in_mem", last_pf, 0);
        step(1, 1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);
        check("wc_pend_later", last_pf, 1);
        step(1, 0, 0, 1, 0, 8'h00);

        // One-shot: memCYCLE three cycles running; src5 appears only in the third.
        step(1, 0, 1, 0, 0, 8'h00); pf_hist[0] = last_pf;
        step(1, 0, 1, 0, 0, 8'h00); pf_hist[1] = last_pf;
        step(1, 0, 1, 0, 0, 8'h20); pf_hist[2] = last_pf;
        step(1, 0, 0, 0, 0, 8'h20); pf_hist[3] = last_pf;
        check("os_t2", pf_hist[2], 0);
        check("os_t3", pf_hist[3], 1);
        step(1, 0, 0, 1, 0, 8'h00);

        // clken low freezes everything.
        step(1, 0, 1, 0, 0, 8'h20);
        step(0, 0, 0, 1, 0, 8'h20);
        check("ck_frozen_pf", last_pf, 1);
        step(1, 0, 0, 0, 0, 8'h20);
        check("ck_capture", dispPF, 12);
        step(1, 0, 0, 1, 0, 8'h00);

        // Saturation: three fault sources captured repeatedly.
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 1, 0, 0, 8'hE0);
            step(1, 0, 0, 0, 0, 8'hE0);
            step(1, 0, 0, 1, 0, 8'h00);
        end
        check("sat_lost2", lostCNT2, 3);

        // Reset in HOLD.
        step(1, 0, 1, 0, 0, 8'h20);
        step(1, 0, 0, 0, 0, 8'h20);
        check("rh_held", dispPF, 12);
        step(0, 0, 0, 0, 1, 8'h00);
        check("rh_dispPF", dispPF, 0);
        check("rh_lost", lostCNT, 0);
        step(1, 1, 0, 0, 0, 8'h02);
        step(1, 0, 0, 0, 0, 8'h02);
        check("rh_armed", dispSRC, 1);

        // Random stimulus.
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0)
                for (int i = 0; i < 8; i++) code[i] = 4'($urandom);
            step(($urandom % 5) != 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
                 ($urandom % 4) == 0, ($urandom % 150) == 0, 8'($urandom & $urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
